// File: rtl/logic_pipe_pkg.sv
// Shared definitions for logic_pipe: operation encoding and the single-lane gate
// evaluation that the datapath replicates across every bit of the operands.
package logic_pipe_pkg;

  typedef enum logic [1:0] {
    LP_AND  = 2'd0,
    LP_OR   = 2'd1,
    LP_XOR  = 2'd2,
    LP_NAND = 2'd3
  } lp_op_e;

  localparam int LP_OP_W = 2;

  // One lane of the unit; the top applies it to each bit position independently.
  function automatic logic lp_eval(lp_op_e op, logic a, logic b);
    logic r;
    case (op)
      LP_OR:   r = a | b;
      LP_XOR:  r = a ^ b;
      LP_NAND: r = ~(a & b);
      default: r = a & b;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/logic_pipe_stage.sv
// Generic elastic pipeline register: one slot, valid/ready on both sides, the
// upstream ready is combinational so a full stage still moves one beat per cycle.
module logic_pipe_stage #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data
);

  logic              valid_q, valid_d;
  logic [DATA_W-1:0] data_q, data_d;

  // The slot can take a new beat when empty or when its current beat leaves now.
  assign in_ready = !valid_q || out_ready;

  // NOTE: every next-state signal gets its hold value first, so no path through
  // this block leaves a variable unassigned and no latch is inferred.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (in_ready) begin
      valid_d = in_valid;
      if (in_valid) begin
        data_d = in_data;
      end
    end
  end

  // NOTE: state uses non-blocking assignments so all flops update together at
  // the edge. The payload is reset as well as the valid bit because the
  // downstream outputs must read zero after reset, not just be flagged invalid.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign out_valid = valid_q;
  assign out_data  = data_q;

endmodule

// File: rtl/logic_pipe.sv
// logic_pipe: two-stage elastic bitwise logic unit (AND/OR/XOR/NAND) with a sequence tag.
// Optional feature: define LOGIC_PIPE_POPCNT_EN to add the out_popcnt result port.
module logic_pipe
  import logic_pipe_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [1:0]       in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_zero,
  output logic             out_ones,
`ifdef LOGIC_PIPE_POPCNT_EN
  output logic [$clog2(WIDTH+1)-1:0] out_popcnt,
`endif
  output logic [TAG_W-1:0] out_tag
);

`ifdef LOGIC_PIPE_POPCNT_EN
  localparam int PC_W = $clog2(WIDTH+1);
`endif

  typedef struct packed {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    lp_op_e           op;
    logic [TAG_W-1:0] tag;
  } s1_t;

  typedef struct packed {
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             ones;
    logic [TAG_W-1:0] tag;
`ifdef LOGIC_PIPE_POPCNT_EN
    logic [PC_W-1:0]  popcnt;
`endif
  } s2_t;

  logic             s1_ready, s1_valid, s2_ready, s2_valid;
  logic             in_fire;
  s1_t              s1_in, s1_out;
  s2_t              s2_in, s2_out;
  logic [WIDTH-1:0] res;
  logic [TAG_W-1:0] tag_q, tag_d;

  // Reset masks ready so nothing offered during reset is counted as accepted.
  assign in_ready = s1_ready && !rst;
  assign in_fire  = in_valid && in_ready;

  assign s1_in = '{a: in_a, b: in_b, op: lp_op_e'(in_op), tag: tag_q};

  assign tag_d = in_fire ? tag_q + TAG_W'(1) : tag_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      tag_q <= '0;
    end else begin
      tag_q <= tag_d;
    end
  end

  logic_pipe_stage #(.DATA_W($bits(s1_t))) u_s1 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_fire),
    .in_ready  (s1_ready),
    .in_data   (s1_in),
    .out_valid (s1_valid),
    .out_ready (s2_ready),
    .out_data  (s1_out)
  );

  always_comb begin
    res = '0;
    for (int i = 0; i < WIDTH; i++) begin
      res[i] = lp_eval(s1_out.op, s1_out.a[i], s1_out.b[i]);
    end
  end

`ifdef LOGIC_PIPE_POPCNT_EN
  logic [PC_W-1:0] popcnt;

  always_comb begin
    popcnt = '0;
    for (int i = 0; i < WIDTH; i++) begin
      popcnt = popcnt + PC_W'(res[i]);
    end
  end
`endif

  always_comb begin
    s2_in        = '0;
    s2_in.result = res;
    s2_in.zero   = (res == '0);
    s2_in.ones   = &res;
    s2_in.tag    = s1_out.tag;
`ifdef LOGIC_PIPE_POPCNT_EN
    s2_in.popcnt = popcnt;
`endif
  end

  logic_pipe_stage #(.DATA_W($bits(s2_t))) u_s2 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (s1_valid),
    .in_ready  (s2_ready),
    .in_data   (s2_in),
    .out_valid (s2_valid),
    .out_ready (out_ready),
    .out_data  (s2_out)
  );

  assign out_valid  = s2_valid;
  assign out_result = s2_out.result;
  assign out_zero   = s2_out.zero;
  assign out_ones   = s2_out.ones;
  assign out_tag    = s2_out.tag;
`ifdef LOGIC_PIPE_POPCNT_EN
  assign out_popcnt = s2_out.popcnt;
`endif

endmodule

// File: tb/tb_logic_pipe.sv
// Self-checking bench for logic_pipe: directed stimulus with a scoreboard queue
// filled on every accepted beat and drained as results are consumed.
module tb_logic_pipe;
  import logic_pipe_pkg::*;

  localparam int WIDTH = 8;
  localparam int TAG_W = 4;
  localparam int PC_W  = $clog2(WIDTH+1);

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] in_a = '0;
  logic [WIDTH-1:0] in_b = '0;
  logic [1:0]       in_op = '0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [WIDTH-1:0] out_result;
  logic             out_zero;
  logic             out_ones;
  logic [TAG_W-1:0] out_tag;
`ifdef LOGIC_PIPE_POPCNT_EN
  logic [PC_W-1:0]  out_popcnt;
`endif

  logic_pipe #(.WIDTH(WIDTH), .TAG_W(TAG_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_a       (in_a),
    .in_b       (in_b),
    .in_op      (in_op),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_zero   (out_zero),
    .out_ones   (out_ones),
`ifdef LOGIC_PIPE_POPCNT_EN
    .out_popcnt (out_popcnt),
`endif
    .out_tag    (out_tag)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [WIDTH-1:0] res;
    logic             zero;
    logic             ones;
    logic [TAG_W-1:0] tag;
    logic [PC_W-1:0]  pc;
    int               acc_edge;
    bit               exact;
  } exp_t;

  exp_t             sb[$];
  exp_t             mon_e;
  int               mon_lat;
  int               checks = 0;
  int               errors = 0;
  int               edge_cnt = 0;
  int               acc_cnt = 0;
  int               out_cnt = 0;
  int               flushed = 0;
  int               base;
  logic [TAG_W-1:0] tag_model = '0;
  bit               expect_exact = 1'b1;

  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", name, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                 input logic [1:0] op, input logic [TAG_W-1:0] tag);
    exp_t e;
    case (op)
      2'd0:    e.res = a & b;
      2'd1:    e.res = a | b;
      2'd2:    e.res = a ^ b;
      default: e.res = ~(a & b);
    endcase
    e.zero     = (e.res == '0);
    e.ones     = (e.res == {WIDTH{1'b1}});
    e.tag      = tag;
    e.pc       = PC_W'($countones(e.res));
    e.acc_edge = 0;
    e.exact    = 1'b0;
    return e;
  endfunction

  always @(posedge clk) edge_cnt++;

  // Scoreboard monitor: everything sampled mid-cycle, effects land on the next edge.
  always @(negedge clk) begin
    if (rst) begin
      flushed   += sb.size();
      sb.delete();
      tag_model = '0;
    end else begin
      if (out_valid && out_ready) begin
        check("sb_nonempty", 32'(sb.size() != 0), 1);
        if (sb.size() != 0) begin
          mon_e   = sb.pop_front();
          mon_lat = edge_cnt + 1 - mon_e.acc_edge;
          out_cnt++;
          check("result", out_result, mon_e.res);
          check("zero",   out_zero,   mon_e.zero);
          check("ones",   out_ones,   mon_e.ones);
          check("tag",    out_tag,    mon_e.tag);
`ifdef LOGIC_PIPE_POPCNT_EN
          check("popcnt", out_popcnt, mon_e.pc);
`endif
          if (mon_e.exact) check("latency", mon_lat, 2);
          else             check("latency_min", 32'(mon_lat >= 2), 1);
        end
      end
      if (in_valid && in_ready) begin
        mon_e          = model(in_a, in_b, in_op, tag_model);
        mon_e.acc_edge = edge_cnt + 1;
        mon_e.exact    = expect_exact;
        sb.push_back(mon_e);
        tag_model++;
        acc_cnt++;
      end
    end
  end

  task automatic send(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                      input logic [1:0] op, input bit need_ready);
    int waited;
    waited   = 0;
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    in_op    = op;
    @(negedge clk);
    if (need_ready) check("in_ready_stream", in_ready, 1);
    while (!in_ready) begin
      waited++;
      if (waited > 20) begin
        check("send_accept_budget", in_ready, 1);
        break;
      end
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 50) begin
      @(negedge clk);
      #1;
      n++;
    end
    check("drain_empty", sb.size(), 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready",   in_ready,   0);
    check("rst_out_valid",  out_valid,  0);
    check("rst_out_result", out_result, 0);
    check("rst_out_tag",    out_tag,    0);
    check("rst_out_zero",   out_zero,   0);
    check("rst_out_ones",   out_ones,   0);
`ifdef LOGIC_PIPE_POPCNT_EN
    check("rst_out_popcnt", out_popcnt, 0);
`endif
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("ready_after_rst", in_ready, 1);
    @(posedge clk);
    #1;

    // Each op on F0/3C: 30, FC, CC, CF with tags 0..3.
    send(8'hF0, 8'h3C, LP_AND,  1'b1);
    send(8'hF0, 8'h3C, LP_OR,   1'b1);
    send(8'hF0, 8'h3C, LP_XOR,  1'b1);
    send(8'hF0, 8'h3C, LP_NAND, 1'b1);

    // Back-to-back stream of 20 beats; tags run 4..15 then wrap to 0..7.
    for (int i = 0; i < 20; i++) begin
      send(8'(i * 29 + 3), 8'(i * 53) ^ 8'h5A, 2'(i), 1'b1);
    end
    drain();

    // Stall: two beats fill the pipe, the third waits.
    expect_exact = 1'b0;
    out_ready    = 1'b0;
    base         = acc_cnt;
    send(8'hAA, 8'h0F, LP_AND, 1'b0);
    send(8'h55, 8'h33, LP_OR,  1'b0);
    in_valid = 1'b1;
    in_a     = 8'hC3;
    in_b     = 8'h3C;
    in_op    = LP_XOR;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("stall_in_ready",   in_ready,   0);
      check("stall_out_valid",  out_valid,  1);
      check("stall_out_result", out_result, 8'h0A);
    end
    check("stall_accepted", acc_cnt - base, 2);
    @(posedge clk);
    #1 out_ready = 1'b1;
    send(8'hC3, 8'h3C, LP_XOR, 1'b0);
    drain();
    expect_exact = 1'b1;

    // Flag boundaries: all-zero and all-ones results.
    send(8'h0F, 8'hF0, LP_AND,  1'b1);
    send(8'h00, 8'h00, LP_NAND, 1'b1);
`ifdef LOGIC_PIPE_POPCNT_EN
    send(8'hFF, 8'h0F, LP_XOR,  1'b1);
`endif
    drain();

    // Reset with two beats in flight.
    out_ready = 1'b0;
    send(8'h11, 8'h22, LP_OR,  1'b0);
    send(8'h33, 8'h44, LP_AND, 1'b0);
    rst      = 1'b1;
    in_valid = 1'b1;
    in_a     = 8'h77;
    in_b     = 8'h88;
    in_op    = LP_OR;
    @(negedge clk);
    check("ready_in_rst", in_ready, 0);
    @(posedge clk);
    #1;
    rst       = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    check("rst2_out_valid",  out_valid,  0);
    check("rst2_out_result", out_result, 0);
    check("rst2_out_tag",    out_tag,    0);
    check("rst2_out_zero",   out_zero,   0);
    check("rst2_out_ones",   out_ones,   0);
    send(8'h5A, 8'hA5, LP_XOR, 1'b1);
    drain();
    repeat (4) @(posedge clk);

    check("beats_out", out_cnt, acc_cnt - flushed);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
